// File: rtl/led_pattern_decoder.sv
// Receiver for the rotating holiday-lights LED bus: decodes run length and head position, counts rotation steps, checks step timing.
// Optional build macro ERR_CLEAR_EN adds an err_clr input that clears the sticky error flags.
module led_pattern_decoder #(
    parameter int unsigned STEP_PERIOD = 100_000_000,
    parameter int unsigned TOL         = 16
) (
    input  logic        clk,
    input  logic        rst,
`ifdef ERR_CLEAR_EN
    input  logic        err_clr,
`endif
    input  logic [15:0] led_in,
    output logic [2:0]  code_out,
    output logic        code_valid,
    output logic [3:0]  pos_out,
    output logic        step_pulse,
    output logic        reload_pulse,
    output logic [15:0] step_count,
    output logic        running,
    output logic        pattern_err,
    output logic        timing_err
);

    // Acceptance window for the step interval; upper bound saturates, lower bound never drops below 1.
    localparam logic [32:0] HI_SUM = 33'(STEP_PERIOD) + 33'(TOL);
    localparam logic [31:0] HI_LIM = HI_SUM[32] ? 32'hFFFF_FFFF : HI_SUM[31:0];
    localparam logic [31:0] LO_LIM = (TOL >= STEP_PERIOD) ? 32'd1 : 32'(STEP_PERIOD - TOL);

    function automatic logic [15:0] rotl1(input logic [15:0] v);
        return {v[14:0], v[15]};
    endfunction

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // A bit is a run head when it is set and its circular lower neighbour is clear.
    function automatic logic [15:0] heads16(input logic [15:0] v);
        return v & ~rotl1(v);
    endfunction

    function automatic logic is_legal(input logic [15:0] v);
        logic [4:0] ones;
        ones = popcnt16(v);
        return (popcnt16(heads16(v)) == 5'd1) && (ones >= 5'd1) && (ones <= 5'd8);
    endfunction

    function automatic logic [3:0] head_pos(input logic [15:0] v);
        logic [15:0] h;
        logic [3:0]  p;
        h = heads16(v);
        p = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (h[i]) begin
                p = 4'(i);
            end
        end
        return p;
    endfunction

    logic [15:0] led_q, led_d;
    logic [15:0] led_prev_q, led_prev_d;
    logic [31:0] ival_q, ival_d;
    logic [2:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic [3:0]  pos_q, pos_d;
    logic        step_q, step_d;
    logic        reload_q, reload_d;
    logic [15:0] scount_q, scount_d;
    logic        run_q, run_d;
    logic        perr_q, perr_d;
    logic        terr_q, terr_d;

    logic        cur_legal;
    logic        prev_legal;
    logic [3:0]  cur_pos;
    logic [2:0]  cur_code;
    logic        is_rot;
    logic        clr_req;

    assign cur_legal  = is_legal(led_q);
    assign prev_legal = is_legal(led_prev_q);
    assign cur_pos    = head_pos(led_q);
    assign cur_code   = 3'(popcnt16(led_q) - 5'd1);
    assign is_rot     = (led_q == rotl1(led_prev_q));

`ifdef ERR_CLEAR_EN
    assign clr_req = err_clr;
`else
    assign clr_req = 1'b0;
`endif

    always_comb begin
        led_d      = led_in;
        led_prev_d = led_q;
        ival_d     = (ival_q == 32'hFFFF_FFFF) ? ival_q : ival_q + 32'd1;
        code_d     = code_q;
        valid_d    = valid_q;
        pos_d      = pos_q;
        step_d     = 1'b0;
        reload_d   = 1'b0;
        scount_d   = scount_q;
        run_d      = run_q;
        // Clear is applied first so an error detected in the same cycle overrides it.
        perr_d     = clr_req ? 1'b0 : perr_q;
        terr_d     = clr_req ? 1'b0 : terr_q;

        if (led_q != led_prev_q) begin
            ival_d = 32'd1;
            if (!cur_legal) begin
                perr_d  = 1'b1;
                valid_d = 1'b0;
                run_d   = 1'b0;
            end else if (is_rot && prev_legal && valid_q) begin
                step_d   = 1'b1;
                scount_d = scount_q + 16'd1;
                pos_d    = cur_pos;
                if (run_q && ((ival_q < LO_LIM) || (ival_q > HI_LIM))) begin
                    terr_d = 1'b1;
                end
                run_d    = 1'b1;
            end else begin
                reload_d = 1'b1;
                code_d   = cur_code;
                pos_d    = cur_pos;
                valid_d  = 1'b1;
                scount_d = 16'd0;
                run_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= 16'd0;
            led_prev_q <= 16'd0;
            ival_q     <= 32'd0;
            code_q     <= 3'd0;
            valid_q    <= 1'b0;
            pos_q      <= 4'd0;
            step_q     <= 1'b0;
            reload_q   <= 1'b0;
            scount_q   <= 16'd0;
            run_q      <= 1'b0;
            perr_q     <= 1'b0;
            terr_q     <= 1'b0;
        end else begin
            led_q      <= led_d;
            led_prev_q <= led_prev_d;
            ival_q     <= ival_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            pos_q      <= pos_d;
            step_q     <= step_d;
            reload_q   <= reload_d;
            scount_q   <= scount_d;
            run_q      <= run_d;
            perr_q     <= perr_d;
            terr_q     <= terr_d;
        end
    end

    assign code_out     = code_q;
    assign code_valid   = valid_q;
    assign pos_out      = pos_q;
    assign step_pulse   = step_q;
    assign reload_pulse = reload_q;
    assign step_count   = scount_q;
    assign running      = run_q;
    assign pattern_err  = perr_q;
    assign timing_err   = terr_q;

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench for led_pattern_decoder with STEP_PERIOD=10, TOL=0.
module tb_led_pattern_decoder;

    logic        clk;
    logic        rst;
    logic [15:0] led_in;
    logic [2:0]  code_out;
    logic        code_valid;
    logic [3:0]  pos_out;
    logic        step_pulse;
    logic        reload_pulse;
    logic [15:0] step_count;
    logic        running;
    logic        pattern_err;
    logic        timing_err;
`ifdef ERR_CLEAR_EN
    logic        err_clr;
`endif

    int total = 0;
    int bad   = 0;

    led_pattern_decoder #(.STEP_PERIOD(10), .TOL(0)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef ERR_CLEAR_EN
        .err_clr      (err_clr),
`endif
        .led_in       (led_in),
        .code_out     (code_out),
        .code_valid   (code_valid),
        .pos_out      (pos_out),
        .step_pulse   (step_pulse),
        .reload_pulse (reload_pulse),
        .step_count   (step_count),
        .running      (running),
        .pattern_err  (pattern_err),
        .timing_err   (timing_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // New value is sampled on the first edge and classified on the second.
    task automatic apply(input logic [15:0] v);
        led_in = v;
        tick();
        tick();
    endtask

    function automatic logic [31:0] all_outs();
        return {3'd0, code_out, code_valid, pos_out, step_pulse, reload_pulse,
                step_count, running, pattern_err, timing_err};
    endfunction

    initial begin
        rst    = 1'b1;
        led_in = 16'h0000;
`ifdef ERR_CLEAR_EN
        err_clr = 1'b0;
`endif
        idle(2);
        chk("reset_outs", all_outs(), 32'd0);

        // Scenario 1: first legal pattern is a reload
        rst = 1'b0;
        led_in = 16'h0007;
        tick();
        chk("s1_no_early_reload", {31'd0, reload_pulse}, 32'd0);
        tick();
        chk("s1_reload", {31'd0, reload_pulse}, 32'd1);
        chk("s1_code", {29'd0, code_out}, 32'd2);
        chk("s1_pos", {28'd0, pos_out}, 32'd0);
        chk("s1_valid", {31'd0, code_valid}, 32'd1);
        chk("s1_count", {16'd0, step_count}, 32'd0);
        chk("s1_running", {31'd0, running}, 32'd0);
        idle(1);
        chk("s1_reload_one_cycle", {31'd0, reload_pulse}, 32'd0);

        // Scenario 2: three on-time rotations
        idle(7);
        apply(16'h000E);
        chk("s2_step1", {31'd0, step_pulse}, 32'd1);
        chk("s2_no_reload", {31'd0, reload_pulse}, 32'd0);
        chk("s2_count1", {16'd0, step_count}, 32'd1);
        chk("s2_running", {31'd0, running}, 32'd1);
        idle(8);
        apply(16'h001C);
        chk("s2_count2", {16'd0, step_count}, 32'd2);
        idle(8);
        apply(16'h0038);
        chk("s2_step3", {31'd0, step_pulse}, 32'd1);
        chk("s2_count3", {16'd0, step_count}, 32'd3);
        chk("s2_pos3", {28'd0, pos_out}, 32'd3);
        chk("s2_timing_ok", {31'd0, timing_err}, 32'd0);
        idle(1);
        chk("s2_step_one_cycle", {31'd0, step_pulse}, 32'd0);

        // Scenario 3: multi-bit jump is a reload; rotation wraps through bit 15
        idle(7);
        apply(16'h8001);
        chk("s3_reload", {31'd0, reload_pulse}, 32'd1);
        chk("s3_pos15", {28'd0, pos_out}, 32'd15);
        chk("s3_code1", {29'd0, code_out}, 32'd1);
        chk("s3_count0", {16'd0, step_count}, 32'd0);
        chk("s3_no_perr", {31'd0, pattern_err}, 32'd0);
        idle(8);
        apply(16'h0003);
        chk("s3_wrap_step", {31'd0, step_pulse}, 32'd1);
        chk("s3_pos0", {28'd0, pos_out}, 32'd0);
        chk("s3_code1b", {29'd0, code_out}, 32'd1);

        // Scenario 4: short first step after reload is tolerated, short armed step is not
        idle(8);
        apply(16'h0030);
        chk("s4_reload", {31'd0, reload_pulse}, 32'd1);
        chk("s4_pos4", {28'd0, pos_out}, 32'd4);
        idle(7);
        apply(16'h0060);
        chk("s4_first_step", {31'd0, step_pulse}, 32'd1);
        chk("s4_first_short_ok", {31'd0, timing_err}, 32'd0);
        idle(7);
        apply(16'h00C0);
        chk("s4_short_step", {31'd0, step_pulse}, 32'd1);
        chk("s4_timing_err", {31'd0, timing_err}, 32'd1);
        idle(8);
        apply(16'h0180);
        chk("s4_good_step", {31'd0, step_pulse}, 32'd1);
        chk("s4_timing_sticky", {31'd0, timing_err}, 32'd1);
        chk("s4_pos7", {28'd0, pos_out}, 32'd7);

        // Scenario 5: two separate runs are illegal
        idle(8);
        apply(16'h0101);
        chk("s5_perr", {31'd0, pattern_err}, 32'd1);
        chk("s5_invalid", {31'd0, code_valid}, 32'd0);
        chk("s5_not_running", {31'd0, running}, 32'd0);
        chk("s5_code_held", {29'd0, code_out}, 32'd1);
        chk("s5_pos_held", {28'd0, pos_out}, 32'd7);
        chk("s5_no_pulses", {30'd0, step_pulse, reload_pulse}, 32'd0);
        apply(16'h00FF);
        chk("s5_reload", {31'd0, reload_pulse}, 32'd1);
        chk("s5_code7", {29'd0, code_out}, 32'd7);
        chk("s5_perr_sticky", {31'd0, pattern_err}, 32'd1);
        chk("s5_valid", {31'd0, code_valid}, 32'd1);
`ifdef ERR_CLEAR_EN
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s5_clr_perr", {31'd0, pattern_err}, 32'd0);
        chk("s5_clr_terr", {31'd0, timing_err}, 32'd0);
        led_in = 16'h0505;
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("s5_new_err_wins", {31'd0, pattern_err}, 32'd1);
`endif

        // Scenario 6: reset in the middle of a run
        apply(16'h0003);
        chk("s6_reload", {31'd0, reload_pulse}, 32'd1);
        idle(8);
        apply(16'h0006);
        idle(8);
        apply(16'h000C);
        idle(8);
        apply(16'h0018);
        idle(8);
        apply(16'h0030);
        idle(8);
        apply(16'h0060);
        chk("s6_count5", {16'd0, step_count}, 32'd5);
        rst = 1'b1;
        tick();
        chk("s6_reset_outs", all_outs(), 32'd0);
        rst = 1'b0;
        apply(16'h0001);
        chk("s6_reload_after_rst", {31'd0, reload_pulse}, 32'd1);
        chk("s6_code0", {29'd0, code_out}, 32'd0);
        chk("s6_pos0", {28'd0, pos_out}, 32'd0);
        chk("s6_valid", {31'd0, code_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_decoder.md
Name: led_pattern_decoder

Overview:
- Receiver end of the holiday-lights LED bus.
- Watches the 16-bit rotating LED pattern, decodes it back to the 3-bit switch code and the rotation position, counts rotation steps and checks step timing.
- Flags illegal patterns and off-period steps.
- Used as an on-board self-checker and as the scoreboard front end in lights benches.

Parameters:
STEP_PERIOD, 100_000_000, expected clk cycles between consecutive rotation steps (1 to 2^32-1)
TOL, 16, allowed deviation in cycles either side of STEP_PERIOD

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
led_in  input  16  LED bus being observed
code_out  output  3  decoded switch code (run length of ones minus 1)
code_valid  output  1  1 while current pattern is legal
pos_out  output  4  bit index of run head (lowest-order one of the contiguous run, circularly)
step_pulse  output  1  one-cycle pulse per detected single left rotation
reload_pulse  output  1  one-cycle pulse when a new legal pattern appears that is not a rotation
step_count  output  16  rotation steps since reset/reload, wraps at 16 bits
running  output  1  1 after first step following a reload; timing checks armed
pattern_err  output  1  sticky: illegal pattern seen
timing_err  output  1  sticky: step interval outside STEP_PERIOD±TOL

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; internal led_q, led_prev = 0; interval counter = 0.
- Pipeline:
  - Edge N: led_q <= led_in.
  - Edge N+1: classify led_q against led_prev; update outputs; led_prev <= led_q.
  - Outputs reflect led_in two edges after sampling.
- Legal pattern: circular rotation of a single contiguous run of k ones, k = 1..8, remaining bits 0. code = k-1.
  - pos = unique p with led_q[p]=1 and led_q[(p+15) mod 16]=0.
  - All-zero, all-ones, runs >8, or multiple runs are illegal.
- Interval counter: +1 every cycle, saturating at 2^32-1. Set to 1 on any step, reload or illegal event.
- Classification per cycle, evaluated in this priority order:
  1. led_q == led_prev: no event.
  2. led_q illegal:
     - pattern_err <= 1 (sticky); code_valid <= 0; running <= 0.
     - code_out/pos_out hold last legal values.
  3. led_q == {led_prev[14:0], led_prev[15]}, led_prev legal and code_valid=1: step event.
     - step_pulse=1; step_count+1 (wraps 0xFFFF->0); pos_out updated.
     - If running=1 and the interval at this edge is outside [STEP_PERIOD-TOL, STEP_PERIOD+TOL]: timing_err <= 1.
     - running <= 1.
  4. Otherwise legal (reload):
     - reload_pulse=1; code_out, pos_out, code_valid=1 updated.
     - step_count <= 0; running <= 0.
- Interval semantics: the value at the step edge equals the number of clk cycles between the two changes of led_in.
- Lower clamp: if TOL ≥ STEP_PERIOD, the lower bound clamps to 1.
- step_pulse and reload_pulse never assert together.
- Reset mid-operation:
  - Everything returns to reset values the next edge.
  - The first legal pattern after reset is a reload, because led_prev=0 is illegal.
- Rotation by more than one bit in one cycle is treated as a reload, not an error.

Optional Feature:
ERR_CLEAR_EN:
- Defined: adds input port err_clr (1 bit).
  - err_clr=1 at an edge clears pattern_err and timing_err.
  - A same-cycle new error wins (flag stays 1).
- Undefined: port absent; sticky flags clear only on rst.

Test Plan:
All scenarios use STEP_PERIOD=10, TOL=0.
1. rst, then led_in=0x0007 held -> reload_pulse at 2nd edge; code_out=2, pos_out=0, code_valid=1, step_count=0, running=0.
2. From 0x0007, rotate every 10 cycles to 0x000E, 0x001C, 0x0038 -> three step_pulses; step_count=3; pos_out=3; running=1; timing_err=0.
3. Rotation wrap: 0x8001 (k=2) -> 0x0003 -> step; pos_out 15 then 0; code_out=1.
4. Step after 9 cycles while running -> timing_err=1 and stays 1 over later good steps; first step after a reload at 9 cycles -> timing_err stays 0.
5. led_in=0x0101 -> pattern_err=1, code_valid=0, running=0. Then 0x00FF -> reload, code_out=7, pattern_err still 1. With ERR_CLEAR_EN: err_clr pulse -> pattern_err=0.
6. rst asserted mid-run (step_count=5) -> next edge all outputs 0. Hold 0x0001 -> reload, code_out=0.
